// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_ctrl_pkg
// Brief  : Shared constants, types and helpers for the MIPS pipeline control.
// Rev    : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE        = 2'd3;
    localparam int         MULT_LAT_DEFAULT = 5;
    localparam int         DIV_LAT_DEFAULT  = 10;
    localparam int         CNT_W_DEFAULT    = 4;
    localparam logic [4:0] REG_ZERO         = 5'd0;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A producer is too late when its result appears after the consumer needs it.
    function automatic logic raw_hazard(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic [1:0] tnew,
        input logic [1:0] tuse
    );
        return (src == dst) && (tnew > tuse);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_stall_ctrl_if
// Brief  : Pipeline hazard/stall control signal bundle with master/slave views.
// Rev    : 1.0  initial release
// ============================================================================
interface hazard_stall_ctrl_if;

    logic [4:0]  Rs_D;
    logic [4:0]  Rt_D;
    logic [1:0]  Tuse_Rs;
    logic [1:0]  Tuse_Rt;
    logic [4:0]  A3_E;
    logic [1:0]  Tnew_E;
    logic [4:0]  A3_M;
    logic [1:0]  Tnew_M;
    logic        MD_Use_D;
    logic        MD_Start_E;
    logic        MD_IsDiv_E;
    logic        MD_Cancel;
    logic        En_PC;
    logic        En_FD;
    logic        Flush_E;
    logic        MD_Busy;
    logic [31:0] Stall_Cnt;

    modport master (
        output Rs_D, Rt_D, Tuse_Rs, Tuse_Rt, A3_E, Tnew_E, A3_M, Tnew_M,
               MD_Use_D, MD_Start_E, MD_IsDiv_E, MD_Cancel,
        input  En_PC, En_FD, Flush_E, MD_Busy, Stall_Cnt
    );

    modport slave (
        input  Rs_D, Rt_D, Tuse_Rs, Tuse_Rt, A3_E, Tnew_E, A3_M, Tnew_M,
               MD_Use_D, MD_Start_E, MD_IsDiv_E, MD_Cancel,
        output En_PC, En_FD, Flush_E, MD_Busy, Stall_Cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module : md_busy_tracker
// Brief  : Countdown of the multiply/divide unit occupancy after issue.
// Rev    : 1.0  initial release
// ============================================================================
module md_busy_tracker
    import mips_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  wire logic CLK,
    input  wire logic RESET,
    input  wire logic md_start,
    input  wire logic md_is_div,
    input  wire logic md_cancel,
    output logic      md_busy
);

    logic [CNT_W-1:0] r_md_cnt;
    md_state_e        w_state;

    // Cancel wins over a same-cycle start; a start while busy simply reloads.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_md_cnt <= '0;
        end else if (md_cancel) begin
            r_md_cnt <= '0;
        end else if (md_start) begin
            r_md_cnt <= md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end

    assign w_state = (r_md_cnt != '0) ? MD_BUSY : MD_IDLE;
    assign md_busy = md_start | (w_state == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_stall_ctrl
// Brief  : Tuse/Tnew and mult/div stall detection, F/D hold, E bubble, stall counter.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    hazard_stall_ctrl_if.slave bus
);

    logic        w_stall_rs;
    logic        w_stall_rt;
    logic        w_stall_data;
    logic        w_stall_md;
    logic        w_stall;
    logic        w_md_busy;
    logic [31:0] r_stall_cnt;

    // $0 is never a real dependency, and an unused operand never stalls.
    assign w_stall_rs = (bus.Rs_D != REG_ZERO) && (bus.Tuse_Rs != TUSE_NONE) &&
                        (raw_hazard(bus.Rs_D, bus.A3_E, bus.Tnew_E, bus.Tuse_Rs) ||
                         raw_hazard(bus.Rs_D, bus.A3_M, bus.Tnew_M, bus.Tuse_Rs));
    assign w_stall_rt = (bus.Rt_D != REG_ZERO) && (bus.Tuse_Rt != TUSE_NONE) &&
                        (raw_hazard(bus.Rt_D, bus.A3_E, bus.Tnew_E, bus.Tuse_Rt) ||
                         raw_hazard(bus.Rt_D, bus.A3_M, bus.Tnew_M, bus.Tuse_Rt));

    assign w_stall_data = w_stall_rs | w_stall_rt;
    assign w_stall_md   = bus.MD_Use_D & w_md_busy;
    assign w_stall      = w_stall_data | w_stall_md;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_tracker (
        .CLK       (CLK),
        .RESET     (RESET),
        .md_start  (bus.MD_Start_E),
        .md_is_div (bus.MD_IsDiv_E),
        .md_cancel (bus.MD_Cancel),
        .md_busy   (w_md_busy)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.En_PC     = ~w_stall;
    assign bus.En_FD     = ~w_stall;
    assign bus.Flush_E   = w_stall;
    assign bus.MD_Busy   = w_md_busy;
    assign bus.Stall_Cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_stall_ctrl
// Brief  : Directed self-checking bench for hazard_stall_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp_stall);
        chk({tag, "_en_pc"},   {31'd0, bus.En_PC},   {31'd0, ~exp_stall});
        chk({tag, "_en_fd"},   {31'd0, bus.En_FD},   {31'd0, ~exp_stall});
        chk({tag, "_flush_e"}, {31'd0, bus.Flush_E}, {31'd0, exp_stall});
    endtask

    task automatic quiet();
        bus.Rs_D = 5'd0;  bus.Rt_D = 5'd0;
        bus.Tuse_Rs = 2'd3; bus.Tuse_Rt = 2'd3;
        bus.A3_E = 5'd0;  bus.Tnew_E = 2'd0;
        bus.A3_M = 5'd0;  bus.Tnew_M = 2'd0;
        bus.MD_Use_D = 1'b0; bus.MD_Start_E = 1'b0;
        bus.MD_IsDiv_E = 1'b0; bus.MD_Cancel = 1'b0;
    endtask

    // Advance one clock, landing 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b0;
        quiet();
        #3;
        chk("rst_en_pc",   {31'd0, bus.En_PC},   32'd1);
        chk("rst_en_fd",   {31'd0, bus.En_FD},   32'd1);
        chk("rst_flush",   {31'd0, bus.Flush_E}, 32'd0);
        chk("rst_busy",    {31'd0, bus.MD_Busy}, 32'd0);
        chk("rst_cnt",     bus.Stall_Cnt,        32'd0);
        #4 RESET = 1'b1;
        tick();

        // Load-use: lw $1 in E, consumer needs rs next cycle.
        bus.Rs_D = 5'd1; bus.Tuse_Rs = 2'd1; bus.A3_E = 5'd1; bus.Tnew_E = 2'd2;
        #1 chk_stall("lu_stall", 1'b1);
        tick();
        bus.A3_E = 5'd0; bus.Tnew_E = 2'd0; bus.A3_M = 5'd1; bus.Tnew_M = 2'd1;
        #1 chk_stall("lu_release", 1'b0);
        chk("lu_cnt", bus.Stall_Cnt, 32'd1);
        tick();

        // $0 is never a hazard.
        quiet();
        bus.Rs_D = 5'd0; bus.A3_E = 5'd0; bus.Tnew_E = 2'd2; bus.Tuse_Rs = 2'd0;
        #1 chk_stall("zero_reg", 1'b0);
        tick();

        // rt hazard against M.
        quiet();
        bus.Rt_D = 5'd5; bus.Tuse_Rt = 2'd0; bus.A3_M = 5'd5; bus.Tnew_M = 2'd1;
        #1 chk_stall("rt_m_stall", 1'b1);
        tick();
        bus.Tuse_Rt = 2'd3;
        #1 chk_stall("rt_unused", 1'b0);
        chk("rt_cnt", bus.Stall_Cnt, 32'd2);
        // Tnew equal to Tuse is covered by forwarding.
        quiet();
        bus.Rs_D = 5'd7; bus.A3_E = 5'd7; bus.Tnew_E = 2'd1; bus.Tuse_Rs = 2'd1;
        #1 chk_stall("tnew_eq_tuse", 1'b0);
        tick();

        // Multiply: start in cycle 0, mfhi in D from cycle 1.
        quiet();
        bus.MD_Start_E = 1'b1;
        #1 chk("mul_busy_c0", {31'd0, bus.MD_Busy}, 32'd1);
        chk_stall("mul_c0", 1'b0);
        tick();
        bus.MD_Start_E = 1'b0; bus.MD_Use_D = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1 chk_stall($sformatf("mul_c%0d", i), 1'b1);
            tick();
        end
        #1 chk("mul_busy_c6", {31'd0, bus.MD_Busy}, 32'd0);
        chk_stall("mul_c6", 1'b0);
        chk("mul_cnt", bus.Stall_Cnt, 32'd7);
        tick();

        // Divide, then cancel in cycle 3 together with a data stall.
        quiet();
        bus.MD_Start_E = 1'b1; bus.MD_IsDiv_E = 1'b1;
        tick();
        bus.MD_Start_E = 1'b0; bus.MD_IsDiv_E = 1'b0;
        tick();
        #1 chk("div_busy_c2", {31'd0, bus.MD_Busy}, 32'd1);
        tick();
        bus.MD_Cancel = 1'b1;
        bus.Rs_D = 5'd3; bus.Tuse_Rs = 2'd0; bus.A3_E = 5'd3; bus.Tnew_E = 2'd1;
        #1 chk_stall("cancel_data_c3", 1'b1);
        tick();
        quiet();
        bus.MD_Use_D = 1'b1;
        #1 chk("div_busy_c4", {31'd0, bus.MD_Busy}, 32'd0);
        chk_stall("mflo_c4", 1'b0);
        chk("cancel_cnt", bus.Stall_Cnt, 32'd8);
        tick();

        // Async reset in the middle of a divide.
        quiet();
        bus.MD_Start_E = 1'b1; bus.MD_IsDiv_E = 1'b1;
        tick();
        bus.MD_Start_E = 1'b0; bus.MD_IsDiv_E = 1'b0;
        tick(); tick(); tick();
        bus.MD_Use_D = 1'b1;
        #1 chk_stall("div_c4_stall", 1'b1);
        #2 RESET = 1'b0;
        #1 chk("arst_busy", {31'd0, bus.MD_Busy}, 32'd0);
        chk("arst_cnt", bus.Stall_Cnt, 32'd0);
        chk_stall("arst", 1'b0);
        #1 RESET = 1'b1;
        quiet();
        tick();

        // Start while busy reloads with the new latency.
        bus.MD_Start_E = 1'b1;
        tick();
        bus.MD_Start_E = 1'b0;
        tick();
        bus.MD_Start_E = 1'b1; bus.MD_IsDiv_E = 1'b1;
        tick();
        bus.MD_Start_E = 1'b0; bus.MD_IsDiv_E = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #1 chk("reload_busy_last", {31'd0, bus.MD_Busy}, 32'd1);
        tick();
        #1 chk("reload_idle", {31'd0, bus.MD_Busy}, 32'd0);
        chk("reload_cnt", bus.Stall_Cnt, 32'd0);

        // Saturation from a preloaded counter.
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.r_stall_cnt;
        #1 chk("sat_preload", bus.Stall_Cnt, 32'hFFFF_FFFD);
        bus.Rs_D = 5'd9; bus.Tuse_Rs = 2'd0; bus.A3_E = 5'd9; bus.Tnew_E = 2'd2;
        tick();
        #1 chk("sat_1", bus.Stall_Cnt, 32'hFFFF_FFFE);
        tick();
        #1 chk("sat_2", bus.Stall_Cnt, 32'hFFFF_FFFF);
        tick();
        #1 chk("sat_3", bus.Stall_Cnt, 32'hFFFF_FFFF);
        quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
